// File: rtl/param_code_lock.sv
// Keypad code lock: collects CODE_LEN digits, judges the whole sequence, drives unlock/lockout/alarm.
// Latency: outputs decode registered state; result visible from the edge that samples the last digit.
// Backpressure: none; buttons are ignored while in lockout, alarm or (except relock/program) open.
// Optional in-field reprogramming is enabled by defining PARAM_CODE_LOCK_PROG_EN.
module param_code_lock #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int OPEN_CYC    = 500,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIGIT_W-1:0]               entry,
  input  logic                             enter_btn,
  input  logic                             clear_btn,
  input  logic                             lock_btn,
  input  logic                             prog_btn,
  output logic                             unlock,
  output logic                             lockout,
  output logic                             alarm,
  output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int CODE_W  = CODE_LEN * DIGIT_W;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int TMR_MAX = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

`ifdef PARAM_CODE_LOCK_PROG_EN
  typedef enum logic [2:0] {ENTRY, OPEN, LOCKOUT, ALARM, PROG} state_t;
`else
  typedef enum logic [2:0] {ENTRY, OPEN, LOCKOUT, ALARM} state_t;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
  logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic                mismatch_q, mismatch_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CODE_W-1:0]   code_w;
  logic [DIGIT_W-1:0]  code_digit;
  logic                last_digit;
  logic                mism_now;
  logic [FAIL_W-1:0]   fail_inc;

`ifdef PARAM_CODE_LOCK_PROG_EN
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic [CODE_W-1:0]   shadow_shift;
  assign code_w       = code_q;
  // New digit enters at the bottom so the first-entered digit ends up most significant.
  assign shadow_shift = (shadow_q << DIGIT_W) | CODE_W'(entry);
`else
  logic                unused_prog;
  assign code_w      = DEFAULT_CODE;
  assign unused_prog = prog_btn;
`endif

  // Digit of the stored code expected at the current position (position 0 is the MSB digit).
  assign code_digit = DIGIT_W'(code_w >> (DIGIT_W * (CODE_LEN - 1 - int'(digit_cnt_q))));
  assign last_digit = (digit_cnt_q == CNT_W'(CODE_LEN - 1));
  assign mism_now   = mismatch_q | (entry != code_digit);
  assign fail_inc   = fail_cnt_q + FAIL_W'(1);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ENTRY;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      timer_q     <= '0;
`ifdef PARAM_CODE_LOCK_PROG_EN
      code_q      <= DEFAULT_CODE;
      shadow_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      mismatch_q  <= mismatch_d;
      timer_q     <= timer_d;
`ifdef PARAM_CODE_LOCK_PROG_EN
      code_q      <= code_d;
      shadow_q    <= shadow_d;
`endif
    end
  end

  // Next-state logic: sequence judging, timers, failure counting and reprogramming.
  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    mismatch_d  = mismatch_q;
    timer_d     = timer_q;
`ifdef PARAM_CODE_LOCK_PROG_EN
    code_d      = code_q;
    shadow_d    = shadow_q;
`endif
    case (state_q)
      ENTRY: begin
        if (clear_btn) begin
          // Abort discards any same-cycle digit and counts no failure.
          digit_cnt_d = '0;
          mismatch_d  = 1'b0;
        end else if (enter_btn) begin
          if (last_digit) begin
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            timer_d     = '0;
            if (!mism_now) begin
              state_d    = OPEN;
              fail_cnt_d = '0;
            end else if (fail_inc == FAIL_W'(MAX_FAILS)) begin
              state_d    = ALARM;
              fail_cnt_d = fail_inc;
            end else begin
              state_d    = LOCKOUT;
              fail_cnt_d = fail_inc;
            end
          end else begin
            digit_cnt_d = digit_cnt_q + CNT_W'(1);
            mismatch_d  = mism_now;
          end
        end
      end
      LOCKOUT: begin
        if (timer_q == TMR_W'(LOCKOUT_CYC - 1)) begin
          state_d = ENTRY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      OPEN: begin
        // Relock (button or timeout) takes priority over a programming request.
        if (lock_btn || (timer_q == TMR_W'(OPEN_CYC - 1))) begin
          state_d = ENTRY;
          timer_d = '0;
`ifdef PARAM_CODE_LOCK_PROG_EN
        end else if (prog_btn) begin
          state_d     = PROG;
          timer_d     = '0;
          digit_cnt_d = '0;
          shadow_d    = '0;
`endif
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
`ifdef PARAM_CODE_LOCK_PROG_EN
      PROG: begin
        if (clear_btn) begin
          state_d     = ENTRY;
          digit_cnt_d = '0;
        end else if (enter_btn) begin
          if (last_digit) begin
            code_d      = shadow_shift;
            state_d     = ENTRY;
            digit_cnt_d = '0;
          end else begin
            shadow_d    = shadow_shift;
            digit_cnt_d = digit_cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      ALARM: begin
        state_d = ALARM;
      end
      default: begin
        state_d = ENTRY;
      end
    endcase
  end

  assign unlock    = (state_q == OPEN);
  assign lockout   = (state_q == LOCKOUT);
  assign alarm     = (state_q == ALARM);
  assign digit_cnt = digit_cnt_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_param_code_lock.sv
// Directed + randomized bench for param_code_lock against a sequence-level reference model.
module tb_param_code_lock;

  localparam int DIGIT_W     = 4;
  localparam int CODE_LEN    = 4;
  localparam int MAX_FAILS   = 3;
  localparam int LOCKOUT_CYC = 8;
  localparam int OPEN_CYC    = 16;
  localparam logic [15:0] DEF_CODE = 16'h1234;
`ifdef PARAM_CODE_LOCK_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   entry = '0;
  logic         enter_btn = 1'b0;
  logic         clear_btn = 1'b0;
  logic         lock_btn = 1'b0;
  logic         prog_btn = 1'b0;
  logic         unlock, lockout, alarm;
  logic [2:0]   digit_cnt;
  logic [1:0]   fail_cnt;

  always #5 clk = ~clk;

  param_code_lock #(
    .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_CYC(LOCKOUT_CYC), .OPEN_CYC(OPEN_CYC), .DEFAULT_CODE(DEF_CODE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .entry(entry), .enter_btn(enter_btn),
    .clear_btn(clear_btn), .lock_btn(lock_btn), .prog_btn(prog_btn),
    .unlock(unlock), .lockout(lockout), .alarm(alarm),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending digits, remaining open/lockout time, failures, alarm, code.
  int got[$];
  int code_m[CODE_LEN];
  int open_left = 0;
  int lock_left = 0;
  int fails = 0;
  bit alarm_m = 1'b0;
  bit prog_m = 1'b0;

  task automatic model_reset();
    got.delete();
    open_left = 0; lock_left = 0; fails = 0; alarm_m = 1'b0; prog_m = 1'b0;
    for (int i = 0; i < CODE_LEN; i++)
      code_m[i] = int'((DEF_CODE >> ((CODE_LEN - 1 - i) * DIGIT_W)) & 16'hF);
  endtask

  task automatic model_step(input bit en, input int d, input bit clr, input bit lk,
                            input bit pg, input bit rs);
    bit ok;
    if (!rs) model_reset();
    else if (alarm_m) begin end
    else if (lock_left > 0) lock_left--;
    else if (open_left > 0) begin
      if (lk || open_left == 1) open_left = 0;
      else if (PROG_EN && pg) begin open_left = 0; prog_m = 1'b1; got.delete(); end
      else open_left--;
    end else if (prog_m) begin
      if (clr) begin prog_m = 1'b0; got.delete(); end
      else if (en) begin
        got.push_back(d);
        if (got.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) code_m[i] = got[i];
          prog_m = 1'b0;
          got.delete();
        end
      end
    end else begin
      if (clr) got.delete();
      else if (en) begin
        got.push_back(d);
        if (got.size() == CODE_LEN) begin
          ok = 1'b1;
          for (int i = 0; i < CODE_LEN; i++) if (got[i] != code_m[i]) ok = 1'b0;
          got.delete();
          if (ok) begin open_left = OPEN_CYC; fails = 0; end
          else begin
            fails++;
            if (fails == MAX_FAILS) alarm_m = 1'b1;
            else lock_left = LOCKOUT_CYC;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, check model against DUT just after the rising edge.
  task automatic tick(input bit en, input int d, input bit clr, input bit lk,
                      input bit pg, input bit rs);
    @(negedge clk);
    enter_btn = en; entry = 4'(d); clear_btn = clr; lock_btn = lk; prog_btn = pg; rst_n = rs;
    @(posedge clk);
    #1;
    vectors++;
    model_step(en, d, clr, lk, pg, rs);
    chk("m_unlock",    32'(unlock),    32'(open_left > 0));
    chk("m_lockout",   32'(lockout),   32'(lock_left > 0));
    chk("m_alarm",     32'(alarm),     32'(alarm_m));
    chk("m_digit_cnt", 32'(digit_cnt), 32'(got.size()));
    chk("m_fail_cnt",  32'(fail_cnt),  32'(fails));
  endtask

  task automatic key(input int d);      tick(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle(input int n);     repeat (n) tick(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic do_reset();            tick(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic relock();              tick(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1); endtask
  task automatic seq(input int a, input int b, input int c, input int e);
    key(a); key(b); key(c); key(e);
  endtask

  initial begin
    model_reset();
    do_reset(); do_reset();
    chk("rst_outputs", 32'({unlock, lockout, alarm, digit_cnt, fail_cnt}), 32'd0);

    // Correct code opens one cycle after the 4th strobe, holds OPEN_CYC cycles.
    key(1); idle(2); key(2); key(3); key(4);
    chk("open_after_4th", 32'(unlock), 32'd1);
    chk("open_fail0", 32'(fail_cnt), 32'd0);
    idle(15);
    chk("open_last_cycle", 32'(unlock), 32'd1);
    idle(1);
    chk("open_timeout", 32'(unlock), 32'd0);

    // Wrong digit is not revealed until the sequence completes; lockout then blocks entry.
    key(1); key(9); key(3);
    chk("no_early_reveal", 32'({unlock, lockout, alarm}), 32'd0);
    chk("dc_three", 32'(digit_cnt), 32'd3);
    key(4);
    chk("lockout_on", 32'(lockout), 32'd1);
    chk("fail_one", 32'(fail_cnt), 32'd1);
    repeat (7) key(1);
    chk("lockout_ignores", 32'(digit_cnt), 32'd0);
    chk("lockout_held", 32'(lockout), 32'd1);
    idle(1);
    chk("lockout_off", 32'(lockout), 32'd0);
    key(1);
    chk("first_after_lockout", 32'(digit_cnt), 32'd1);
    tick(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Clear beats a same-cycle digit and does not count as a failure.
    key(1); key(2);
    tick(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clear_dc", 32'(digit_cnt), 32'd0);
    chk("clear_fail_kept", 32'(fail_cnt), 32'd1);
    seq(1, 2, 3, 4);
    chk("open_after_clear", 32'(unlock), 32'd1);
    chk("success_clears_fail", 32'(fail_cnt), 32'd0);

    // Manual relock on the 5th open cycle.
    idle(4);
    relock();
    chk("lock_btn_relock", 32'(unlock), 32'd0);
    key(1); key(2);
    do_reset();
    chk("reset_mid_seq", 32'(digit_cnt), 32'd0);

    // Relock and timeout in the same cycle give a single relock.
    seq(1, 2, 3, 4); idle(15); relock();
    chk("lock_and_timeout", 32'(unlock), 32'd0);

    // Three consecutive failures raise a sticky alarm.
    seq(5, 5, 5, 5); idle(8);
    seq(1, 2, 3, 5); idle(8);
    seq(0, 0, 0, 0);
    chk("alarm_on", 32'(alarm), 32'd1);
    chk("alarm_fail3", 32'(fail_cnt), 32'd3);
    chk("alarm_no_lockout", 32'(lockout), 32'd0);
    seq(1, 2, 3, 4);
    chk("alarm_absorbs", 32'({unlock, alarm}), 32'd1);
    do_reset();
    chk("alarm_reset", 32'({alarm, fail_cnt}), 32'd0);

    // Reset during lockout.
    seq(9, 9, 9, 9); idle(3); do_reset();
    chk("reset_mid_lockout", 32'({lockout, fail_cnt}), 32'd0);

`ifdef PARAM_CODE_LOCK_PROG_EN
    // Reprogram to 5678, old code rejected, new one accepted, reset restores default.
    seq(1, 2, 3, 4);
    tick(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("prog_drops_unlock", 32'(unlock), 32'd0);
    key(5);
    chk("prog_dc1", 32'(digit_cnt), 32'd1);
    key(6); key(7); key(8);
    chk("prog_done_dc", 32'(digit_cnt), 32'd0);
    seq(1, 2, 3, 4);
    chk("old_code_fails", 32'(lockout), 32'd1);
    idle(8);
    seq(5, 6, 7, 8);
    chk("new_code_opens", 32'(unlock), 32'd1);
    tick(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("lock_beats_prog", 32'(unlock), 32'd0);
    do_reset();
    seq(1, 2, 3, 4);
    chk("default_after_reset", 32'(unlock), 32'd1);
    relock();
`endif

    // Randomized traffic, digits biased towards the current code.
    for (int n = 0; n < 3000; n++) begin
      int r, d, pos;
      bit en, clr, lk, pg, rs;
      r   = int'($urandom_range(0, 99));
      en  = (r < 45);
      clr = (r >= 95);
      pos = (got.size() < CODE_LEN) ? got.size() : 0;
      if ($urandom_range(0, 3) != 0) d = code_m[pos];
      else d = int'($urandom_range(0, 15));
      lk  = ($urandom_range(0, 19) == 0);
      pg  = ($urandom_range(0, 9) == 0);
      if (alarm_m) rs = ($urandom_range(0, 9) != 0);
      else rs = ($urandom_range(0, 499) != 0);
      tick(en, d, clr, lk, pg, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_code_lock.md
# param_code_lock

Parametrised keypad code lock controller: collects a CODE_LEN-digit sequence of DIGIT_W-bit entries, compares the whole sequence against a stored code, and drives unlock, lockout and alarm outputs. Wrong digits are not revealed early; the sequence is judged only after the last digit. Adds a timed lockout after each failure, a sticky alarm after MAX_FAILS consecutive failures, auto-relock, and optional in-field code reprogramming. Sits between the debounced keypad front-end and the actuator/alarm drivers.

## Interface
- DIGIT_W, 4: bits per entered digit.
- CODE_LEN, 4: digits per code, ≥1.
- MAX_FAILS, 3: consecutive failed sequences before alarm, ≥1.
- LOCKOUT_CYC, 1000: cycles entry is blocked after a non-final failure, ≥1.
- OPEN_CYC, 500: cycles unlock stays high before auto-relock, ≥1.
- DEFAULT_CODE, 16'h1234: reset code, CODE_LEN*DIGIT_W bits; first-entered digit is the most significant.

- clk  in  1  clock, single domain.
- rst_n  in  1  reset, synchronous, active-low.
- entry  in  DIGIT_W  digit value, sampled when enter_btn=1.
- enter_btn  in  1  digit strobe; every high cycle is one digit (front-end supplies single-cycle pulses).
- clear_btn  in  1  abort current sequence/programming.
- lock_btn  in  1  manual relock while open.
- prog_btn  in  1  request code programming while open (used only with macro).
- unlock  out  1  lock open.
- lockout  out  1  entry blocked by lockout timer.
- alarm  out  1  sticky alarm.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits accepted in current sequence.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failures.

## Operation
- States: ENTRY, OPEN, LOCKOUT, ALARM, PROG (PROG only with macro).
- Reset (rst_n=0 at edge): state ENTRY, unlock=0, lockout=0, alarm=0, digit_cnt=0, fail_cnt=0, mismatch flag=0, timer=0, stored code=DEFAULT_CODE (reprogrammed code is lost).
- ENTRY: on enter_btn, mismatch |= (entry ≠ code digit[digit_cnt]); digit_cnt+1. On the CODE_LEN-th digit (including it in the compare): match → OPEN, fail_cnt=0; mismatch and fail_cnt+1 < MAX_FAILS → LOCKOUT, fail_cnt+1; mismatch and fail_cnt+1 = MAX_FAILS → ALARM, fail_cnt=MAX_FAILS. digit_cnt and mismatch clear on every exit.
- clear_btn in ENTRY: digit_cnt=0, mismatch=0, no failure counted; clear_btn wins over a same-cycle enter_btn (digit discarded).
- LOCKOUT: all buttons ignored; after LOCKOUT_CYC cycles → ENTRY.
- OPEN: enter_btn/clear_btn ignored; lock_btn or timer expiry → ENTRY; both in the same cycle → single relock.
- ALARM: absorbing; all inputs ignored; exit only via rst_n.
- fail_cnt counts consecutive failures; cleared only by success or reset.

## Timing
- All outputs registered; unlock/lockout/alarm decode the registered state (unlock=1 iff OPEN, etc.).
- Last digit sampled at edge N → unlock (or lockout/alarm) high from edge N; one-cycle latency from strobe.
- unlock high exactly OPEN_CYC cycles absent lock_btn; lock_btn at edge M → unlock low from edge M.
- lockout high exactly LOCKOUT_CYC cycles; first digit accepted on the cycle after lockout falls.
- Reset mid-sequence, mid-lockout, mid-open or in alarm: all outputs return to reset values at that edge.

## Configuration
- PARAM_CODE_LOCK_PROG_EN defined: in OPEN, prog_btn → PROG (unlock drops, timer stops). Next CODE_LEN enter_btn digits are shifted into a shadow register, digit_cnt counting; on the last digit shadow commits to the stored code → ENTRY. clear_btn in PROG → ENTRY, old code kept. prog_btn with lock_btn same cycle: lock_btn wins.
- Undefined: no PROG state, no shadow register; code is constant DEFAULT_CODE; prog_btn ignored.

## Test plan
- Bench params LOCKOUT_CYC=8, OPEN_CYC=16. Digits 1,2,3,4 → unlock=1 one cycle after 4th strobe, held 16 cycles, fail_cnt=0.
- Digits 1,9,3,4 → no output change until 4th strobe; then lockout=1 for 8 cycles, fail_cnt=1; digits during lockout ignored (digit_cnt stays 0).
- Three wrong sequences → fail_cnt=3, alarm=1; subsequent 1,2,3,4 leaves unlock=0; rst_n=0 clears alarm.
- Digits 1,2 then clear_btn together with enter_btn(3) → digit_cnt=0, fail_cnt unchanged; then 1,2,3,4 opens.
- Open, lock_btn on cycle 5 → unlock low from that edge; rst_n asserted mid-sequence → digit_cnt=0.
- PROG_EN: open, prog_btn, enter 5,6,7,8 → 1,2,3,4 fails, 5,6,7,8 opens; after rst_n, 1,2,3,4 opens again.
